// File: rtl/atc_runway_picker_if.sv
// Request/grant bus between the landing-request source and the runway picker.
// The master drives the strobe and direction; the slave returns the one-hot grant.
interface atc_runway_picker_if;
  logic       en;
  logic [1:0] d;
  logic [3:0] signal;

  modport master (output en, output d, input signal);
  modport slave  (input en, input d, output signal);
endinterface

// File: rtl/atc_runway_picker.sv
// Runway picker: grants a free runway on the requested wind axis (lower runway
// first), then holds that runway busy for OCC_CYCLES clocks.
module atc_runway_picker #(
  parameter int unsigned OCC_CYCLES = 4,
  parameter int unsigned TIMER_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  atc_runway_picker_if.slave   bus
);

  logic [TIMER_W-1:0] busy_q [4];
  logic [TIMER_W-1:0] busy_d [4];
  logic [3:0]         signal_q;
  logic [3:0]         signal_d;
  logic [3:0]         grant;
  logic [1:0]         lo_idx;
  logic [1:0]         hi_idx;
  logic               unused_d_msb;

  // Only the axis bit matters: N/S (d[0]=0) -> runways 0/1, E/W -> runways 2/3.
  assign lo_idx       = {bus.d[0], 1'b0};
  assign hi_idx       = {bus.d[0], 1'b1};
  assign unused_d_msb = bus.d[1];

  always_comb begin
    grant = '0;
    if (bus.en) begin
      if (busy_q[lo_idx] == '0) begin
        grant[lo_idx] = 1'b1;
      end else if (busy_q[hi_idx] == '0) begin
        grant[hi_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    signal_d = bus.en ? grant : signal_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (grant[i]) begin
        busy_d[i] = TIMER_W'(OCC_CYCLES);
      end else if (busy_q[i] != '0) begin
        busy_d[i] = busy_q[i] - 1'b1;
      end else begin
        busy_d[i] = busy_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signal_q <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        busy_q[i] <= '0;
      end
    end else begin
      signal_q <= signal_d;
      for (int unsigned i = 0; i < 4; i++) begin
        busy_q[i] <= busy_d[i];
      end
    end
  end

  assign bus.signal = signal_q;

endmodule

// File: tb/tb_atc_runway_picker.sv
// Directed bench for atc_runway_picker with OCC_CYCLES=4: grant order, occupancy
// release timing, axis separation and asynchronous reset.
module tb_atc_runway_picker;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  atc_runway_picker_if bus ();

  atc_runway_picker #(
    .OCC_CYCLES (4),
    .TIMER_W    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] exp);
    n_checks++;
    assert (bus.signal === exp)
      else begin
        n_fail++;
        $error("FAIL %s: signal=%b expected=%b", tag, bus.signal, exp);
      end
  endtask

  // Drive inputs just after a falling edge; return at the next falling edge,
  // i.e. after exactly one rising edge has sampled them.
  task automatic cyc(input logic e, input logic [1:0] dv);
    bus.en = e;
    bus.d  = dv;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.en   = 1'b1;
    bus.d    = 2'd0;

    // Reset held with a live request: no grant may appear.
    @(negedge clk);
    check("rst_hold0", 4'b0000);
    @(negedge clk);
    check("rst_hold1", 4'b0000);
    @(negedge clk);
    check("rst_hold2", 4'b0000);
    rst_n = 1'b1;

    // Fallback to upper runway, then hold when both N-S runways are busy.
    cyc(1'b1, 2'd0);
    check("first_grant_n", 4'b0001);
    cyc(1'b1, 2'd2);
    check("fallback_s", 4'b0010);
    cyc(1'b1, 2'd0);
    check("ns_both_busy", 4'b0000);
    cyc(1'b0, 2'd1);
    check("hold_none", 4'b0000);
    idle(6);

    // Release timing: runway 0 busy through edge k+4, free at k+5.
    cyc(1'b1, 2'd0);
    check("rel_grant_k", 4'b0001);
    cyc(1'b0, 2'd0);
    check("rel_hold_k1", 4'b0001);
    cyc(1'b0, 2'd2);
    check("rel_hold_k2", 4'b0001);
    cyc(1'b0, 2'd0);
    check("rel_hold_k3", 4'b0001);
    cyc(1'b1, 2'd0);
    check("rel_k4_still_busy", 4'b0010);
    cyc(1'b1, 2'd0);
    check("rel_k5_free", 4'b0001);
    idle(6);

    // Axis separation: E-W requests never spill onto N-S runways.
    cyc(1'b1, 2'd1);
    check("ew_first", 4'b0100);
    cyc(1'b1, 2'd3);
    check("ew_fallback", 4'b1000);
    cyc(1'b1, 2'd1);
    check("ew_both_busy", 4'b0000);
    idle(6);

    // Spaced pulses every 5 cycles always find runway 0 free; d ignored while idle.
    for (int p = 0; p < 5; p++) begin
      cyc(1'b1, 2'd0);
      check("spaced_grant", 4'b0001);
      for (int h = 0; h < 4; h++) begin
        cyc(1'b0, 2'($urandom_range(3, 0)));
        check("spaced_hold", 4'b0001);
      end
    end
    idle(6);

    // Reset in the middle of occupancy clears signal at once and frees runways.
    cyc(1'b1, 2'd0);
    check("pre_rst_r0", 4'b0001);
    cyc(1'b1, 2'd2);
    check("pre_rst_r1", 4'b0010);
    bus.en = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("async_rst_drop", 4'b0000);
    @(negedge clk);
    check("async_rst_held", 4'b0000);
    rst_n = 1'b1;
    cyc(1'b1, 2'd2);
    check("post_rst_grant", 4'b0001);
    cyc(1'b1, 2'd3);
    check("post_rst_ew", 4'b0100);
    cyc(1'b1, 2'd0);
    check("post_rst_fallback", 4'b0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
